pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Output stage fed by the SPI register file. It takes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 digital outputs. Each output is held low, driven statically high, or driven by a shared ~3 kHz, 8-bit PWM waveform. Duty changes are double-buffered so a new value only takes effect at a period boundary, and no output produces a runt pulse.

## Interface
Parameters:
- `CLK_DIV`, default 13: system clocks per PWM counter step. With a 10 MHz clk, 13 × 256 = 3328 clocks per period, about 3.005 kHz. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, active-low, synchronous. Sampled on `posedge clk` only.
- `en_reg_out_7_0`  in  8  output enable, channels 7..0.
- `en_reg_out_15_8`  in  8  output enable, channels 15..8.
- `en_reg_pwm_7_0`  in  8  PWM mode select, channels 7..0.
- `en_reg_pwm_15_8`  in  8  PWM mode select, channels 15..8.
- `pwm_duty_cycle`  in  8  requested duty, in units of 1/256. Value 0xFF means 100 %.
- `out`  out  16  channel outputs, registered.
- `period_start`  out  1  one-clock pulse in the first clock of each PWM period, registered.

## Operation
- Prescaler `div_cnt`, width 8:
  - counts 0..CLK_DIV−1 and wraps to 0;
  - `tick` = (`div_cnt` == CLK_DIV−1).
- Period counter `pwm_cnt`, width 8:
  - increments by 1 on `tick`;
  - wraps 255 → 0 naturally.
- Period end = `tick` && `pwm_cnt` == 255.
- Duty shadow `duty_q`, width 8:
  - loads `pwm_duty_cycle` at period end only;
  - holds otherwise, so mid-period writes are ignored until the next period.
- PWM level, combinational: `pwm_lvl` = (`duty_q` == 8'hFF) | (`pwm_cnt` < `duty_q`). Comparison is unsigned 8-bit.
  - duty 0 → always low;
  - duty N in 1..254 → high for N counter steps;
  - duty 255 → always high, with no 1-step low glitch.
- Channel i, with 16-bit `en_out` = {15_8, 7_0} and `en_pwm` likewise:
  - `en_out[i]` = 0 → next `out[i]` = 0, regardless of `en_pwm`;
  - `en_out[i]` = 1 and `en_pwm[i]` = 0 → next `out[i]` = 1;
  - `en_out[i]` = 1 and `en_pwm[i]` = 1 → next `out[i]` = `pwm_lvl`.
- Enable bytes are not shadowed. They apply on the next clock.
- All channels share a single phase: rising edges are aligned at `pwm_cnt` = 0.

## Timing
- Reset (`rst_n` = 0 at a `posedge clk`) clears:
  - `div_cnt` = 0, `pwm_cnt` = 0, `duty_q` = 0;
  - `out` = 16'h0000, `period_start` = 0.
- Reset asserted mid-period aborts the period. The first period after release starts at `pwm_cnt` = 0 with `duty_q` = 0, so PWM channels read low until the first period end.
- Latency:
  - enable or mode change → `out`: 1 clock;
  - `pwm_cnt`/`duty_q` change → `out`: 1 clock, because `out` is registered from `pwm_lvl`.
- Duty write latency runs from the write to the next period end + 1 clock. The worst case is one full period (3328 clocks at default).
- `period_start` is registered from period end. It is high in the same clock that `pwm_cnt` first reads 0 and `out` first reflects the new `duty_q`. Pulse width is exactly 1 clock.
- Simultaneous duty write and period end: the new value is loaded (input sampled that edge).
- `CLK_DIV` = 1:
  - `tick` is high every clock;
  - the period is 256 clocks;
  - behaviour is otherwise identical.
- Period length = CLK_DIV × 256 clocks, exactly, with no drift.

## Structure
- Shared package/header `pwm_defs`:
  - `PWM_CNT_W` = 8, `NUM_CH` = 16, `DUTY_FULL` = 8'hFF;
  - default `CLK_DIV` = 13.
- Sub-module `pwm_timebase`:
  - contains the prescaler, `pwm_cnt`, `duty_q` shadow and period-end detect;
  - outputs `pwm_lvl` and `period_start`.
- Top level holds the 16-channel mux and the `out` register.
- No other hierarchy.

## Test plan
- Reset with all inputs 0xFF → `out` = 0x0000 and `period_start` = 0 during reset. After release with PWM enables 0, `out` = 0xFFFF one clock later.
- `en_out` = 0x00FF, `en_pwm` = 0 → `out` = 0x00FF. Change to 0x8001 → `out` = 0x8001 exactly one clock later.
- Duty 0x80, channel 0 PWM-enabled, default `CLK_DIV` → after the first period end, `out[0]` is high for 1664 clocks and low for 1664 clocks per 3328-clock period. Its rising edge coincides with `period_start`.
- Duty 0x00 → `out[0]` constantly 0. Duty 0xFF → `out[0]` constantly 1 across two or more full periods, with no low clock at `pwm_cnt` = 255.
- Duty changed 0x40 → 0xC0 mid-period → the current period keeps 832 high clocks, and the next period has 2496 high clocks.
- `rst_n` pulsed low for 1 clock mid-period, duty 0x80 → `out[0]` = 0 for the rest of that period. The next `period_start` arrives 3328 clocks after release, and 50 % PWM resumes from there.

Source files
------------

// File: rtl/pwm_peripheral_pkg.sv
// Shared constants for the PWM output stage.
package pwm_defs;

    localparam int unsigned PWM_CNT_W       = 8;
    localparam int unsigned NUM_CH          = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 13;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, double-buffered duty and
// period-boundary pulse.
module pwm_timebase
    import pwm_defs::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
    output logic                 pwm_lvl,
    output logic                 period_start
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]           div_cnt;
    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic [PWM_CNT_W-1:0] duty_q;
    logic                 tick;
    logic                 period_end;
    logic [7:0]           div_nxt;
    logic [PWM_CNT_W-1:0] cnt_nxt;
    logic [PWM_CNT_W-1:0] duty_nxt;

    // Next-state of the counters and duty shadow. The level is taken from the
    // next-state values so that the registered channel outputs line up with
    // pwm_cnt/duty_q in the same clock (rising edge coincides with period_start).
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        period_end = tick && (pwm_cnt == '1);
        div_nxt    = tick ? '0 : div_cnt + 8'd1;
        cnt_nxt    = tick ? pwm_cnt + 8'd1 : pwm_cnt;
        duty_nxt   = period_end ? pwm_duty_cycle : duty_q;
        pwm_lvl    = (duty_nxt == DUTY_FULL) | (cnt_nxt < duty_nxt);
    end

    // Timebase registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            pwm_cnt      <= '0;
            duty_q       <= '0;
            period_start <= 1'b0;
        end else begin
            div_cnt      <= div_nxt;
            pwm_cnt      <= cnt_nxt;
            duty_q       <= duty_nxt;
            period_start <= period_end;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each channel is off, static high or shared PWM.
module pwm_peripheral
    import pwm_defs::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    ch_vec_t en_out;
    ch_vec_t en_pwm;
    ch_vec_t out_nxt;
    logic    pwm_lvl;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwm_duty_cycle (pwm_duty_cycle),
        .pwm_lvl        (pwm_lvl),
        .period_start   (period_start)
    );

    // Per-channel mux: disabled -> 0, static -> 1, PWM mode -> shared level.
    always_comb begin
        en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_nxt = en_out & (~en_pwm | {NUM_CH{pwm_lvl}});
    end

    // Registered channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (CLK_DIV 13 and CLK_DIV 1).
module tb_pwm_peripheral;
    import pwm_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;
    logic [15:0] out_a, out_b;
    logic        ps_a, ps_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b)
    );

    // Reference model: time since reset determines everything.
    int unsigned divs[2] = '{13, 1};
    int unsigned t[2];
    logic [7:0]  deff[2];
    logic [15:0] eo[2];
    logic        eps[2];

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [15:0] exp_out;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        int unsigned p;
        int unsigned cnt;
        logic lvl;
        p = divs[k] * 256;
        if (!rst_n) begin
            t[k] = 0; deff[k] = 8'h00; eo[k] = 16'h0000; eps[k] = 1'b0;
        end else begin
            t[k]++;
            eps[k] = (t[k] % p == 0);
            if (eps[k]) deff[k] = duty;
            cnt = (t[k] / divs[k]) % 256;
            lvl = (deff[k] == 8'hFF) || (cnt < deff[k]);
            eo[k] = en_out & (~en_pwm | {16{lvl}});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("model_out_a", 32'(out_a), 32'(eo[0]));
        chk("model_ps_a", 32'(ps_a), 32'(eps[0]));
        chk("model_out_b", 32'(out_b), 32'(eo[1]));
        chk("model_ps_b", 32'(ps_b), 32'(eps[1]));
    endtask

    task automatic wait_ps(input string name);
        int n;
        step();
        n = 1;
        while (ps_a !== 1'b1 && n < 4000) begin
            step();
            n++;
        end
        chk(name, 32'(ps_a), 32'd1);
    endtask

    // Called on a period_start clock; counts out[0] high over one full period.
    task automatic count_high(output int hi);
        hi = int'(out_a[0]);
        for (int i = 1; i < 3328; i++) begin
            step();
            hi += int'(out_a[0]);
        end
    endtask

    initial begin
        int hi, hi2, n;

        tbl[0] = '{16'h00FF, 16'h0000, 16'h00FF};
        tbl[1] = '{16'h8001, 16'h0000, 16'h8001};
        tbl[2] = '{16'h0000, 16'hFFFF, 16'h0000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[4] = '{16'hFFFF, 16'h00F0, 16'hFF0F};
        tbl[5] = '{16'h5A5A, 16'h0F0F, 16'h5050};
        tbl[6] = '{16'h1234, 16'hFFFF, 16'h0000};
        tbl[7] = '{16'hFFFF, 16'h0000, 16'hFFFF};

        // Reset with every input at all ones.
        rst_n = 1'b0; en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        chk("reset_out", 32'(out_a), 32'h0);
        chk("reset_ps", 32'(ps_a), 32'h0);

        // Release with static-high channels.
        rst_n = 1'b1; en_pwm = 16'h0000;
        step();
        chk("release_out", 32'(out_a), 32'hFFFF);

        // Table vectors, all within the first period (duty_q still 0).
        for (int i = 0; i < 8; i++) begin
            en_out = tbl[i].en_out;
            en_pwm = tbl[i].en_pwm;
            step();
            chk($sformatf("table_%0d", i), 32'(out_a), 32'(tbl[i].exp_out));
        end

        // 50 % duty on channel 0.
        en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
        wait_ps("ps_50");
        chk("rise_at_ps", 32'(out_a[0]), 32'd1);
        count_high(hi);
        chk("high_50", 32'(hi), 32'd1664);
        step();
        chk("period_len", 32'(ps_a), 32'd1);

        // Duty 0 and duty full.
        duty = 8'h00;
        wait_ps("ps_0");
        count_high(hi);
        chk("high_0", 32'(hi), 32'd0);
        duty = 8'hFF;
        wait_ps("ps_ff");
        count_high(hi);
        step();
        count_high(hi2);
        chk("high_ff_2per", 32'(hi + hi2), 32'd6656);

        // Mid-period duty change is deferred to the next period.
        duty = 8'h40;
        wait_ps("ps_40");
        hi = int'(out_a[0]);
        for (int i = 1; i < 3328; i++) begin
            if (i == 100) duty = 8'hC0;
            step();
            hi += int'(out_a[0]);
        end
        chk("high_40_kept", 32'(hi), 32'd832);
        step();
        count_high(hi);
        chk("high_c0", 32'(hi), 32'd2496);

        // One-clock reset pulse mid-period.
        duty = 8'h80;
        wait_ps("ps_rst");
        for (int i = 0; i < 1000; i++) step();
        rst_n = 1'b0;
        step();
        chk("pulse_rst_out", 32'(out_a), 32'h0);
        rst_n = 1'b1;
        n = 0; hi = 0;
        do begin
            step();
            n++;
            if (!ps_a) hi += int'(out_a[0]);
        end while (ps_a !== 1'b1 && n < 4000);
        chk("rst_ps_delay", 32'(n), 32'd3328);
        chk("rst_low_period", 32'(hi), 32'd0);
        count_high(hi);
        chk("rst_resume_50", 32'(hi), 32'd1664);

        // Randomised enables and duty writes against the model.
        for (int i = 0; i < 4 * 3328; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                en_out = 16'($urandom);
                en_pwm = 16'($urandom);
            end
            if ($urandom_range(199, 0) == 0) duty = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
